// File: rtl/line_clear_ctrl_if.sv
// Grid-port and control bundle between line_clear_ctrl, the game FSM and the playfield store.
interface line_clear_if #(
  parameter int COLS    = 10,
  parameter int LINES_W = 10
);
  logic                  start;
  logic                  vblank;
  logic [4:0]            rd_row;
  logic [4*COLS-1:0]     rd_data;
  logic                  wr_en;
  logic [4:0]            wr_row;
  logic [4*COLS-1:0]     wr_data;
  logic                  busy;
  logic                  done;
  logic [4:0]            lines_cleared;
  logic [LINES_W-1:0]    total_lines;

  modport master (
    input  start, vblank, rd_data,
    output rd_row, wr_en, wr_row, wr_data, busy, done, lines_cleared, total_lines
  );

  modport slave (
    output start, vblank, rd_data,
    input  rd_row, wr_en, wr_row, wr_data, busy, done, lines_cleared, total_lines
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Removes completed rows bottom-up, compacts the rest downward and zero-fills the top.
// Define LINE_CLEAR_VBLANK_GATE_EN to let RD/EVAL/FILL advance only while vblank is high.
module line_clear_ctrl #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int LINES_W = 10
) (
  input logic         clk,
  input logic         rst_n,
  line_clear_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, EVAL, FILL, DONE} state_t;

  state_t             state, state_nxt;
  logic [4:0]         src, src_nxt;
  logic [4:0]         dst, dst_nxt;
  logic [4:0]         cnt, cnt_nxt;
  logic [4:0]         lines, lines_nxt;
  logic [LINES_W-1:0] total, total_nxt;
  logic [LINES_W:0]   total_sum;
  logic               row_full;
  logic               adv;

`ifdef LINE_CLEAR_VBLANK_GATE_EN
  assign adv = bus.vblank;
`else
  logic unused_vblank;
  assign unused_vblank = bus.vblank;
  assign adv = 1'b1;
`endif

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (bus.rd_data[4*c +: 4] == 4'd0) row_full = 1'b0;
    end
  end

  assign total_sum = {1'b0, total} + (LINES_W+1)'(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      cnt   <= '0;
      lines <= '0;
      total <= '0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
      dst   <= dst_nxt;
      cnt   <= cnt_nxt;
      lines <= lines_nxt;
      total <= total_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    src_nxt     = src;
    dst_nxt     = dst;
    cnt_nxt     = cnt;
    lines_nxt   = lines;
    total_nxt   = total;
    bus.wr_en   = 1'b0;
    bus.wr_row  = '0;
    bus.wr_data = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          src_nxt   = 5'(ROWS-1);
          dst_nxt   = 5'(ROWS-1);
          cnt_nxt   = '0;
          lines_nxt = '0;
          state_nxt = RD;
        end
      end
      RD: begin
        if (adv) state_nxt = EVAL;
      end
      EVAL: begin
        if (adv) begin
          if (row_full) begin
            cnt_nxt = cnt + 5'd1;
          end else begin
            if (src != dst) begin
              bus.wr_en   = 1'b1;
              bus.wr_row  = dst;
              bus.wr_data = bus.rd_data;
            end
            if (dst != 5'd0) dst_nxt = dst - 5'd1;
          end
          // The row just evaluated counts toward the fill decision, so use the updated count
          if (src == 5'd0) begin
            state_nxt = (cnt_nxt != 5'd0) ? FILL : DONE;
          end else begin
            src_nxt   = src - 5'd1;
            state_nxt = RD;
          end
        end
      end
      FILL: begin
        if (adv) begin
          bus.wr_en  = 1'b1;
          bus.wr_row = dst;
          if (dst == 5'd0) state_nxt = DONE;
          else             dst_nxt   = dst - 5'd1;
        end
      end
      DONE: begin
        lines_nxt = cnt;
        total_nxt = total_sum[LINES_W] ? '1 : total_sum[LINES_W-1:0];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.rd_row        = src;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
  assign bus.lines_cleared = lines;
  assign bus.total_lines   = total;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomised bench for line_clear_ctrl with a compacting playfield model and a registered grid store.
module tb_line_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int LW   = 10;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_clear_if #(.COLS(COLS), .LINES_W(LW)) bus ();

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .LINES_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [4*COLS-1:0] mem      [ROWS];
  logic [4*COLS-1:0] grid_init[ROWS];
  logic              load = 1'b0;
  int                wr_log[$];
  int                idle_dirty = 0;
  int                gate_viol  = 0;
  int                checks_total  = 0;
  int                checks_passed = 0;
  int                total_model   = 0;

  // Grid store: one-cycle registered read, writes land on the same edge
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= grid_init[i];
    end else if (bus.wr_en && bus.wr_row < 5'(ROWS)) begin
      mem[bus.wr_row] <= bus.wr_data;
    end
    bus.rd_data <= mem[bus.rd_row];
  end

  always @(posedge clk) begin
    if (bus.wr_en) wr_log.push_back(int'(bus.wr_row));
    if (!bus.wr_en && (bus.wr_row != 5'd0 || bus.wr_data != '0)) idle_dirty <= idle_dirty + 1;
    if (bus.wr_en && !bus.vblank) gate_viol <= gate_viol + 1;
  end

  initial begin
    bus.vblank = 1'b1;
    forever begin
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
`ifdef LINE_CLEAR_VBLANK_GATE_EN
        bus.vblank = 1'b1;
`else
        bus.vblank = 1'($urandom_range(0, 1));
`endif
      end
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
`ifdef LINE_CLEAR_VBLANK_GATE_EN
        bus.vblank = 1'b0;
`else
        bus.vblank = 1'($urandom_range(0, 1));
`endif
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  function automatic bit is_full(input logic [4*COLS-1:0] row);
    for (int c = 0; c < COLS; c++) if (row[4*c +: 4] == 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4*COLS-1:0] rand_row(input bit full);
    logic [4*COLS-1:0] r;
    for (int c = 0; c < COLS; c++)
      r[4*c +: 4] = full ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
    if (!full) r[4*$urandom_range(0, COLS-1) +: 4] = 4'd0;
    return r;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++) grid_init[r] = rand_row($urandom_range(0, 3) == 0);
  endtask

  task automatic fill_const(input logic [4*COLS-1:0] v);
    for (int r = 0; r < ROWS; r++) grid_init[r] = v;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_output({pfx, "_busy"},  bus.busy, 0);
    check_output({pfx, "_done"},  bus.done, 0);
    check_output({pfx, "_lines"}, bus.lines_cleared, 0);
    check_output({pfx, "_total"}, bus.total_lines, 0);
    check_output({pfx, "_wren"},  bus.wr_en, 0);
    check_output({pfx, "_wrrow"}, bus.wr_row, 0);
    check_output({pfx, "_wrdat"}, bus.wr_data, 0);
    check_output({pfx, "_rdrow"}, bus.rd_row, 0);
  endtask

  // Loads grid_init, runs one clear operation and compares against the compaction model.
  // Entered and left #1 after a rising edge.
  task automatic apply_stimulus(input string name, input int repulse_at, input int reset_at);
    logic [4*COLS-1:0] keep[$];
    logic [4*COLS-1:0] exp_grid[ROWS];
    int k = 0, fmax = -1, nw, exp_total, cyc, done_cyc, busy_gap, base, nlog, dirty0;
`ifdef LINE_CLEAR_VBLANK_GATE_EN
    int gate0 = gate_viol;
`endif
    for (int r = ROWS-1; r >= 0; r--) begin
      if (is_full(grid_init[r])) begin
        k++;
        if (fmax < 0) fmax = r;
      end else begin
        keep.push_back(grid_init[r]);
      end
    end
    nw = (k == 0) ? 0 : fmax + 1;
    for (int r = 0; r < ROWS; r++) exp_grid[r] = '0;
    for (int i = 0; i < keep.size(); i++) exp_grid[ROWS-1-i] = keep[i];
    exp_total = (total_model + k > (1 << LW) - 1) ? (1 << LW) - 1 : total_model + k;

    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    base   = wr_log.size();
    dirty0 = idle_dirty;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    busy_gap = 0;
    done_cyc = -1;
    check_output({name, "_lines_cleared_on_start"}, bus.lines_cleared, 0);
    while (cyc < LIMIT) begin
      if (!bus.busy) busy_gap++;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs({name, "_midreset"});
        @(posedge clk); #1;
        rst_n = 1'b1;
        total_model = 0;
        return;
      end
      if (cyc == repulse_at) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
    end
    check_output({name, "_done_seen"}, done_cyc >= 0, 1);
`ifdef LINE_CLEAR_VBLANK_GATE_EN
    check_output({name, "_done_not_early"}, done_cyc >= 41 + k, 1);
    check_output({name, "_gate_writes"}, gate_viol - gate0, 0);
`else
    check_output({name, "_done_cycle"}, done_cyc, 41 + k);
`endif
    check_output({name, "_busy_gap"}, busy_gap, 0);
    @(posedge clk); #1;
    check_output({name, "_busy_after"}, bus.busy, 0);
    check_output({name, "_done_pulse"}, bus.done, 0);
    check_output({name, "_lines_cleared"}, bus.lines_cleared, k);
    check_output({name, "_total_lines"}, bus.total_lines, exp_total);
    check_output({name, "_idle_bus_dirty"}, idle_dirty - dirty0, 0);
    total_model = exp_total;
    nlog = wr_log.size() - base;
    check_output({name, "_write_count"}, nlog, nw);
    for (int i = 0; i < nlog && i < nw; i++)
      check_output($sformatf("%s_write_row%0d", name, i), wr_log[base+i], nw - 1 - i);
    for (int r = 0; r < ROWS; r++)
      check_output($sformatf("%s_grid_r%0d", name, r), mem[r], exp_grid[r]);
  endtask

  initial begin
    logic [4*COLS-1:0] pat;
    logic [4*COLS-1:0] full_row;
    pat      = 40'h123450789A;
    full_row = 40'h1111111111;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    fill_const('0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill_const('0);
    apply_stimulus("empty", -1, -1);

    fill_const('0);
    grid_init[19] = full_row;
    grid_init[18] = pat;
    for (int r = 1; r < 18; r++) grid_init[r] = rand_row(1'b0);
    apply_stimulus("one_full", -1, -1);

    fill_const('0);
    grid_init[19] = full_row;
    grid_init[18] = pat;
    grid_init[17] = 40'hFEDCBA9876;
    grid_init[16] = full_row;
    grid_init[15] = 40'h2222222222;
    apply_stimulus("four_full", -1, -1);

    fill_random();
    grid_init[0] = full_row;
    apply_stimulus("top_full", -1, -1);

    for (int t = 0; t < 8; t++) begin
      fill_random();
      apply_stimulus($sformatf("rand%0d", t), -1, -1);
    end

    fill_random();
    apply_stimulus("repulse", 5, -1);

    fill_random();
    grid_init[19] = full_row;
    apply_stimulus("reset_mid", -1, 10);
    check_reset_outputs("post_reset");

    fill_random();
    apply_stimulus("after_reset", -1, -1);

    for (int t = 0; t < 60 && total_model < 1020; t++) begin
      if (total_model + 20 <= 1020) fill_const(full_row);
      else begin
        fill_const('0);
        for (int r = 0; r < 1020 - total_model; r++) grid_init[ROWS-1-r] = full_row;
      end
      apply_stimulus($sformatf("fill%0d", t), -1, -1);
    end
    check_output("preset_total", bus.total_lines, 1020);

    fill_random();
    for (int r = 16; r < 20; r++) grid_init[r] = full_row;
    for (int r = 0; r < 16; r++) grid_init[r] = rand_row(1'b0);
    apply_stimulus("saturate", -1, -1);
    check_output("saturated_total", bus.total_lines, 1023);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
